// File: rtl/loop_dispatch.sv
// rtl/loop_dispatch.sv - 1-to-N round-robin (LRU) dispatcher with 1-entry registered output slots
//
// Purpose : hands each accepted input beat to exactly one of PORT_NUM output ports.
//           Ports are ranked in an LRU list (position 0 = highest rank). The port just
//           served drops to the last position; the others keep their relative order.
// Config  : LOOP_DISP_STRICT_EN defined   -> strict rotation, only the rank-0 port is a candidate
//           LOOP_DISP_STRICT_EN undefined -> work-conserving, busy ports are skipped
// Ports   : clk, rst_n (async, active-low)
//           disp_en                  dispatch enable (0 = accept nothing, rank frozen)
//           in_valid/in_ready/in_data  input stream (in_ready combinational)
//           out_valid/out_ready/out_data  per-port registered slots, port p = [p*DATA_W +: DATA_W]
//           disp_oh                  one-hot port loaded this cycle, 0 when no accept
module loop_dispatch #(
    parameter int PORT_NUM = 7,
    parameter int DATA_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       disp_en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic [PORT_NUM-1:0]        out_valid,
    input  logic [PORT_NUM-1:0]        out_ready,
    output logic [PORT_NUM*DATA_W-1:0] out_data,
    output logic [PORT_NUM-1:0]        disp_oh
);

    localparam int W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    // rank_q[0] is the highest-ranked (least recently served) port
    logic [W-1:0]        rank_q [PORT_NUM];
    logic [W-1:0]        rank_d [PORT_NUM];
    logic [PORT_NUM-1:0] elig;
    logic [W-1:0]        sel_pos;
    logic [W-1:0]        sel_port;
    logic                sel_any;
    logic                accept;
`ifndef LOOP_DISP_STRICT_EN
    logic [PORT_NUM-1:0] pos_elig;
`endif

    always_comb begin
        // A slot can take a new beat if it is empty or is being drained this cycle
        elig    = ~out_valid | out_ready;
        sel_any = 1'b0;
        sel_pos = '0;
`ifdef LOOP_DISP_STRICT_EN
        sel_any = elig[rank_q[0]];
`else
        // Eligibility re-ordered by rank position; the lowest set bit wins
        for (int i = 0; i < PORT_NUM; i++) begin
            pos_elig[i] = elig[rank_q[i]];
        end
        for (int i = PORT_NUM - 1; i >= 0; i--) begin
            if (pos_elig[i]) begin
                sel_any = 1'b1;
                sel_pos = W'(i);
            end
        end
`endif
        sel_port = rank_q[sel_pos];
        in_ready = disp_en & sel_any;
        accept   = in_ready & in_valid;

        disp_oh = '0;
        if (accept) begin
            disp_oh[sel_port] = 1'b1;
        end

        // Served port moves to the tail; entries ranked below it shift up one place
        rank_d = rank_q;
        if (accept) begin
            for (int i = 0; i < PORT_NUM - 1; i++) begin
                if (W'(i) >= sel_pos) begin
                    rank_d[i] = rank_q[i + 1];
                end
            end
            rank_d[PORT_NUM-1] = sel_port;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
            for (int i = 0; i < PORT_NUM; i++) begin
                rank_q[i] <= W'(i);
            end
        end else begin
            rank_q <= rank_d;
            for (int p = 0; p < PORT_NUM; p++) begin
                // Load wins over drain so a same-cycle drain+refill keeps the slot full
                if (accept && (sel_port == W'(p))) begin
                    out_valid[p]                   <= 1'b1;
                    out_data[p*DATA_W +: DATA_W]   <= in_data;
                end else if (out_ready[p]) begin
                    out_valid[p] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_loop_dispatch.sv
// tb/tb_loop_dispatch.sv - scoreboard testbench for loop_dispatch
module tb_loop_dispatch;

    localparam int N  = 7;
    localparam int DW = 32;

`ifdef LOOP_DISP_STRICT_EN
    localparam int T6_PORT = 3;
`else
    localparam int T6_PORT = 5;
`endif

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              disp_en;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic [N-1:0]      out_valid;
    logic [N-1:0]      out_ready;
    logic [N*DW-1:0]   out_data;
    logic [N-1:0]      disp_oh;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int   t2_port [8] = '{3, 4, 5, 6, 0, 1, 3, 4};
    int   t3_port [7] = '{5, 6, 0, 1, 3, 4, 2};

    loop_dispatch #(.PORT_NUM(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .disp_en   (disp_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .disp_oh   (disp_oh)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Push the expected result, then present the beat until it is accepted
    task automatic send(input logic [31:0] d, input int port, output int lat);
        exp_t e;
        e.port = port;
        e.data = d;
        exp_q.push_back(e);
        in_data  = d;
        in_valid = 1'b1;
        lat      = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            lat++;
            if (lat > 20) begin
                checks++;
                errors++;
                $display("FAIL send_timeout data=%0h actual=no_accept required=accept", d);
                void'(exp_q.pop_back());
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT dispatches, checks the slot a cycle later
    logic        pend_v = 1'b0;
    int          pend_p;
    logic [31:0] pend_d;

    always @(negedge clk) begin
        exp_t e;
        if (pend_v) begin
            checks++;
            if (!out_valid[pend_p] || out_data[pend_p*DW +: DW] !== pend_d) begin
                errors++;
                $display("FAIL slot_load port=%0d actual=%0b/%0h required=1/%0h",
                         pend_p, out_valid[pend_p], out_data[pend_p*DW +: DW], pend_d);
            end
            pend_v = 1'b0;
        end
        checks++;
        if (!$onehot0(disp_oh)) begin
            errors++;
            $display("FAIL disp_oh_onehot0 actual=%b required=onehot0", disp_oh);
        end
        if (disp_oh != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_dispatch actual=%b required=none", disp_oh);
            end else begin
                e = exp_q.pop_front();
                if (disp_oh !== N'(1 << e.port)) begin
                    errors++;
                    $display("FAIL dispatch_port data=%0h actual=%b required=%b",
                             e.data, disp_oh, N'(1 << e.port));
                end
                pend_v = 1'b1;
                pend_p = e.port;
                pend_d = e.data;
            end
        end
    end

    initial begin
        int lat;
        rst_n     = 1'b0;
        disp_en   = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = '1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_out_data", 64'(out_data == '0), 64'h1);
        chk("reset_in_ready", 64'(in_ready), 64'h1);
        chk("reset_disp_oh", 64'(disp_oh), 64'h0);
        @(posedge clk);
        #1;

        // 1: plain rotation with every port ready
        for (int i = 0; i < 14; i++) begin
            send(32'(i), i % N, lat);
            chk("t1_no_stall", 64'(lat), 64'h0);
        end
        idle(2);
        chk("t1_drained", 64'(out_valid), 64'h0);

`ifdef LOOP_DISP_STRICT_EN
        // 5: strict rotation stalls on a blocked port instead of skipping it
        for (int i = 0; i < 9; i++) begin
            send(32'h60 + 32'(i), i % N, lat);
            if (i == 2) out_ready[2] = 1'b0;
        end
        in_data = 32'h69;
        repeat (3) begin
            @(negedge clk);
            chk("t5_stall_in_ready", 64'(in_ready), 64'h0);
            chk("t5_stall_disp_oh", 64'(disp_oh), 64'h0);
        end
        @(posedge clk);
        #1 out_ready[2] = 1'b1;
        send(32'h69, 2, lat);
        chk("t5_release_lat", 64'(lat), 64'h0);
        idle(2);
`else
        // 2: a blocked port is skipped and keeps its data; on release it is served first
        send(32'h0, 0, lat);
        send(32'h1, 1, lat);
        send(32'h2, 2, lat);
        out_ready[2] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(32'h3 + 32'(i), t2_port[i], lat);
        end
        chk("t2_hold_valid", 64'(out_valid[2]), 64'h1);
        chk("t2_hold_data", 64'(out_data[2*DW +: DW]), 64'h2);
        out_ready[2] = 1'b1;
        send(32'hB, 2, lat);
        idle(2);

        // 3: all slots full -> stall; a single ready refills that port in the same cycle
        out_ready = '0;
        for (int i = 0; i < N; i++) begin
            send(32'h20 + 32'(i), t3_port[i], lat);
        end
        begin
            exp_t e;
            e.port = 4;
            e.data = 32'h27;
            exp_q.push_back(e);
        end
        in_data = 32'h27;
        repeat (3) begin
            @(negedge clk);
            chk("t3_full_in_ready", 64'(in_ready), 64'h0);
            chk("t3_full_valid", 64'(out_valid), 64'h7f);
        end
        @(posedge clk);
        #1 out_ready = 7'b0010000;
        @(negedge clk);
        chk("t3_pulse_in_ready", 64'(in_ready), 64'h1);
        chk("t3_pulse_disp_oh", 64'(disp_oh), 64'h10);
        @(posedge clk);
        #1;
        out_ready = '0;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("t3_refill_valid", 64'(out_valid), 64'h7f);
        chk("t3_old_slot_held", 64'(out_data[5*DW +: DW]), 64'h20);
        @(posedge clk);
        #1 out_ready = '1;
        idle(2);
`endif

        // 6: asynchronous reset mid-stream clears slots at once and restarts at port 0
        out_ready = '0;
        send(32'h40, T6_PORT, lat);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 64'(out_valid), 64'h0);
        chk("t6_async_data", 64'(out_data == '0), 64'h1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = '1;
        @(posedge clk);
        #1;

        // 4: disabled dispatch freezes acceptance and rank; resumes with the next LRU port
        send(32'h50, 0, lat);
        send(32'h51, 1, lat);
        send(32'h52, 2, lat);
        send(32'h53, 3, lat);
        out_ready = '0;
        disp_en   = 1'b0;
        in_data   = 32'h54;
        repeat (5) begin
            @(negedge clk);
            chk("t4_dis_in_ready", 64'(in_ready), 64'h0);
            chk("t4_dis_disp_oh", 64'(disp_oh), 64'h0);
            chk("t4_dis_valid", 64'(out_valid), 64'h08);
        end
        @(posedge clk);
        #1;
        disp_en   = 1'b1;
        out_ready = '1;
        send(32'h54, 4, lat);
        idle(3);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
